// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file access controller.
package regfile_ctrl_pkg;

    localparam int RFC_NREQ   = 2;
    localparam int RFC_ADDR_W = 5;
    localparam int RFC_DATA_W = 32;

    localparam logic [RFC_ADDR_W-1:0] RFC_ZERO_REG = '0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } rfc_state_e;

    typedef struct packed {
        logic                  owner;
        logic                  we;
        logic [RFC_ADDR_W-1:0] addr_wr;
        logic [RFC_ADDR_W-1:0] addr_rd1;
        logic [RFC_ADDR_W-1:0] addr_rd2;
        logic [RFC_DATA_W-1:0] wdata;
    } rfc_cmd_t;

    function automatic logic is_zero_reg(input logic [RFC_ADDR_W-1:0] addr);
        return addr == RFC_ZERO_REG;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: on contention the requester that did not win last time is granted.
module rr_arbiter_2 (
    input  logic [1:0] valid,
    input  logic       accept,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (accept) begin
            if (valid == 2'b11)
                grant = last_grant ? 2'b01 : 2'b10;
            else
                grant = valid;
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Shares the register file between the core datapath and a debug/loader port,
// sequencing each request and returning data from the file's registered read.
module regfile_access_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int ADDR_W = RFC_ADDR_W,
    parameter int DATA_W = RFC_DATA_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [RFC_NREQ-1:0]              req_valid,
    output logic [RFC_NREQ-1:0]              req_ready,
    input  logic [RFC_NREQ-1:0]              req_we,
    input  logic [RFC_NREQ-1:0][ADDR_W-1:0]  req_addr_wr,
    input  logic [RFC_NREQ-1:0][ADDR_W-1:0]  req_addr_rd1,
    input  logic [RFC_NREQ-1:0][ADDR_W-1:0]  req_addr_rd2,
    input  logic [RFC_NREQ-1:0][DATA_W-1:0]  req_wdata,
    output logic [RFC_NREQ-1:0]              rsp_valid,
    output logic [DATA_W-1:0]                rsp_rdata1,
    output logic [DATA_W-1:0]                rsp_rdata2,
    output logic                             busy,
    output logic                             rf_wr_rd_en,
    output logic [ADDR_W-1:0]                rf_addr_wr,
    output logic [ADDR_W-1:0]                rf_addr_rd1,
    output logic [ADDR_W-1:0]                rf_addr_rd2,
    output logic [DATA_W-1:0]                rf_write_data,
    input  logic [DATA_W-1:0]                rf_read_port_1,
    input  logic [DATA_W-1:0]                rf_read_port_2
);

    rfc_state_e          state;
    rfc_cmd_t            cmd;
    logic                last_grant;
    logic [RFC_NREQ-1:0] grant;
    logic                win;

    rr_arbiter_2 u_arb (
        .valid      (req_valid),
        .accept     (state == IDLE),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign win       = grant[1];
    assign req_ready = grant;
    assign busy      = (state != IDLE);

    // Register-file side always reflects the last command; only the enable is qualified.
    assign rf_addr_wr    = cmd.addr_wr;
    assign rf_addr_rd1   = cmd.addr_rd1;
    assign rf_addr_rd2   = cmd.addr_rd2;
    assign rf_write_data = cmd.wdata;
    assign rf_wr_rd_en   = (state == ISSUE) && cmd.we && !is_zero_reg(cmd.addr_wr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cmd        <= '0;
            last_grant <= 1'b1;
            rsp_valid  <= '0;
            rsp_rdata1 <= '0;
            rsp_rdata2 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|(req_valid & grant)) begin
                        cmd.owner    <= win;
                        cmd.we       <= req_we[win];
                        cmd.addr_wr  <= req_addr_wr[win];
                        cmd.addr_rd1 <= req_addr_rd1[win];
                        cmd.addr_rd2 <= req_addr_rd2[win];
                        cmd.wdata    <= req_wdata[win];
                        last_grant   <= win;
                        state        <= ISSUE;
                    end
                end
                ISSUE: state <= cmd.we ? IDLE : WAIT;
                WAIT: begin
                    // The file's read data is valid this cycle; x0 is forced to zero here.
                    rsp_rdata1 <= is_zero_reg(cmd.addr_rd1) ? '0 : rf_read_port_1;
                    rsp_rdata2 <= is_zero_reg(cmd.addr_rd2) ? '0 : rf_read_port_2;
                    rsp_valid  <= cmd.owner ? 2'b10 : 2'b01;
                    state      <= RESP;
                end
                RESP: begin
                    rsp_valid <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
